// File: rtl/uart_rx_word_assembler.sv
// 8N1 UART receiver that packs four bytes (first byte in [7:0]) into a 32-bit bus word.
// Optional build macro UART_RX_ASCII_EN maps ASCII '0'-'9' to 0x00-0x09 before packing.
module uart_rx_word_assembler #(
  parameter int DATA_WIDTH = 32,
  parameter int UART_Nbit  = 8,
  parameter int baudrate   = 5,
  parameter int clk_freq   = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SerialDataIn,
  input  logic                  clr_rx_flag,
  output logic [DATA_WIDTH-1:0] UART_word,
  output logic [31:0]           Rx_flag_out,
  output logic [1:0]            rx_byte_count
);

  localparam int BIT_CLKS = clk_freq / baudrate;
  localparam int HALF     = BIT_CLKS / 2;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam int IW       = (UART_Nbit > 1) ? $clog2(UART_Nbit) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(BIT_CLKS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_Nbit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [IW-1:0]          idx, idx_nx;
  logic [UART_Nbit-1:0]   shreg, shreg_nx;
  logic                   commit, ferr;

  logic                   sync1, rxs, rxs_d;
  logic [UART_Nbit-1:0]   rx_byte;
  logic [DATA_WIDTH-1:0]  asm_word, asm_nx;
  logic [1:0]             byte_cnt;
  logic                   word_valid, frame_err, overrun;
  logic                   wv_set;

  // Synchroniser resets high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= SerialDataIn;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    shreg_nx = shreg;
    commit   = 1'b0;
    ferr     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rxs_d && !rxs) state_nx = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nx = '0;
          if (rxs) state_nx = IDLE;
          else begin
            state_nx = DATA;
            idx_nx   = '0;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_M1) begin
          cnt_nx   = '0;
          shreg_nx = {rxs, shreg[UART_Nbit-1:1]};
          if (idx == IDX_LAST) state_nx = STOP;
          else idx_nx = idx + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_M1) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          if (rxs) commit = 1'b1;
          else     ferr   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_byte = shreg;
`ifdef UART_RX_ASCII_EN
    if (shreg >= UART_Nbit'(8'h30) && shreg <= UART_Nbit'(8'h39))
      rx_byte = shreg - UART_Nbit'(8'h30);
`endif
  end

  // New bytes enter at the top so after four commits the first byte sits in [7:0].
  assign asm_nx = {rx_byte, asm_word[DATA_WIDTH-1:UART_Nbit]};
  assign wv_set = commit && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_word   <= '0;
      byte_cnt   <= '0;
      UART_word  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ferr) begin
        asm_word <= '0;
        byte_cnt <= '0;
      end else if (commit) begin
        asm_word <= asm_nx;
        byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt == 2'd3) UART_word <= asm_nx;
      end
      word_valid <= wv_set | (word_valid & ~clr_rx_flag);
      frame_err  <= ferr   | (frame_err  & ~clr_rx_flag);
      overrun    <= (wv_set & word_valid & ~clr_rx_flag) | (overrun & ~clr_rx_flag);
    end
  end

  assign Rx_flag_out   = {29'b0, overrun, frame_err, word_valid};
  assign rx_byte_count = byte_cnt;

endmodule

// File: doc/uart_rx_word_assembler.md
# uart_rx_word_assembler

- Receive-side companion to the 32-bit UART transmit controller. Samples the serial line, deserialises 8N1 bytes and packs four consecutive bytes into one 32-bit word for the MIPS memory-mapped bus.
- First byte received lands in bits [7:0], matching the transmitter's LSB-byte-first order.
- Status is exposed as a zero-extended 32-bit flag word; software clears it with a pulse.

## Interface
- DATA_WIDTH, 32, bus word width; fixed at 32.
- UART_Nbit, 8, data bits per frame.
- baudrate, 5, bit rate (simulation scale).
- clk_freq, 50, clock frequency; BIT_CLKS = clk_freq/baudrate must be an integer ≥ 4; HALF = BIT_CLKS/2.
- clk  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- SerialDataIn  in  1  asynchronous serial line, idle high.
- clr_rx_flag  in  1  active-high one-cycle pulse; clears all status bits.
- UART_word  out  32  last completed word.
- Rx_flag_out  out  32  {29'b0, overrun, frame_err, word_valid}.
- rx_byte_count  out  2  bytes held toward the current partial word (0–3).

## Operation
- Two-flop synchroniser on SerialDataIn. All decisions use the synchronised signal `rxs`.
- Bit FSM states:
  - IDLE: wait for `rxs` to be 1 then 0 (falling edge) → START. The baud counter loads 0.
  - START: after HALF cycles, sample `rxs`. If 1, it is a false start → IDLE. If 0 → DATA, bit index 0.
  - DATA: every BIT_CLKS cycles, sample one bit into the shift register, LSB first. After bit UART_Nbit-1 → STOP.
  - STOP: after BIT_CLKS cycles, sample `rxs`.
    - 1: the byte is valid and is committed.
    - 0: framing error. Set frame_err, discard the byte and any partial word, and reset rx_byte_count to 0.
    - Either case → IDLE. A new start needs `rxs` to return high first.
- Word packing: a committed byte shifts in at [31:24] of the assembly register and existing contents shift right by 8. rx_byte_count increments and wraps 3→0.
- On the 4th commit:
  - UART_word ← assembled word.
  - word_valid ← 1.
  - If word_valid was already 1 and no clear arrives the same cycle, overrun ← 1. UART_word is overwritten regardless (newest wins).
- clr_rx_flag clears word_valid, frame_err and overrun. UART_word and partial-word state are unaffected.
- Simultaneous set and clear of any status bit: set wins. No overrun is flagged when a clear coincides with completion.
- Default/unreachable FSM state → IDLE.

## Timing
- t0 is the first cycle `rxs` = 0. The serial line reaches `rxs` 2 clocks after SerialDataIn changes.
- Sample points, relative to t0:
  - start bit: t0+HALF
  - data bit i: t0+HALF+(i+1)·BIT_CLKS
  - stop bit: t0+HALF+(UART_Nbit+1)·BIT_CLKS
- Commit, byte count update, UART_word and Rx_flag_out updates are registered. They are visible the cycle after the stop sample.
- Back-to-back frames are accepted: the next falling edge may arrive any cycle after the stop sample.
- Reset values: UART_word = 0, Rx_flag_out = 0, rx_byte_count = 0, FSM = IDLE, synchroniser flops = 1.
- Reset mid-frame aborts the frame and drops any partial word.

## Configuration
- UART_RX_ASCII_EN defined:
  - Each committed byte in 0x30–0x39 ('0'–'9') is translated to 0x00–0x09 before packing.
  - All other bytes pass unchanged.
  - Translation is combinational on the commit path and adds no latency.
- Undefined: bytes are packed raw.

## Test plan
- BIT_CLKS = 10. Send frames 0x44, 0x33, 0x22, 0x11 back-to-back → UART_word = 0x11223344 and Rx_flag_out = 0x1 the cycle after the 4th stop sample. rx_byte_count sequence is 1, 2, 3, 0.
- 3-cycle low glitch on an idle line → no state change; flags stay 0 and rx_byte_count stays 0.
- 0xAA then a frame whose stop bit is 0 → Rx_flag_out = 0x2 and rx_byte_count = 0. The next four good frames 0x01, 0x02, 0x03, 0x04 → UART_word = 0x04030201 and Rx_flag_out = 0x3.
- Two full words with no clear → UART_word = second word and Rx_flag_out = 0x5. clr_rx_flag pulse → 0x0.
- clr_rx_flag asserted in the same cycle as 4th-byte completion while word_valid = 1 → Rx_flag_out = 0x1, no overrun.
- With UART_RX_ASCII_EN, send '1', '2', 'A', '9' → UART_word = 0x09410201. Without the macro → 0x39413231.
- Reset asserted mid-DATA after 2 bytes → all outputs 0. The next 4 frames form a fresh word.
